// File: rtl/hls_run_controller.sv
// Multi-run launcher/profiler for an HLS kernel using the start_port/done_port handshake.
// Define HLS_RUN_MINMAX_EN to build the min/max latency trackers; otherwise they read as 0.
module hls_run_controller #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RUNS_W     = 8,
    parameter int unsigned TIMEOUT    = 200000000,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [RUNS_W-1:0] cmd_runs,
    input  logic              cmd_abort,
    output logic              kernel_reset,
    output logic              kernel_start,
    input  logic              kernel_done,
    output logic              busy,
    output logic              res_valid,
    output logic [RUNS_W-1:0] run_idx,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              batch_done,
    output logic              timed_out,
    output logic              aborted,
    output logic [CNT_W-1:0]  total_cycles,
    output logic [CNT_W-1:0]  min_cycles,
    output logic [CNT_W-1:0]  max_cycles
);

    localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RstW-1:0]  RstLast    = RstW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    typedef enum logic [2:0] {StIdle, StKrst, StStart, StWait, StReport, StFinish} state_e;

    state_e            state;
    logic [RUNS_W-1:0] runs_q;
    logic [RstW-1:0]   rst_cnt;
    logic [CNT_W-1:0]  cnt;

    logic [CNT_W-1:0] cur_cycle;
    logic [CNT_W:0]   total_sum;
    logic             last_run;
    logic             accept;

    // cnt holds the cycles already spent in this run; cur_cycle counts the present one too
    assign cur_cycle = cnt + CNT_W'(1);
    assign total_sum = {1'b0, total_cycles} + {1'b0, run_cycles};
    assign last_run  = ({1'b0, run_idx} + (RUNS_W + 1)'(1)) >= {1'b0, runs_q};
    assign accept    = (state == StIdle) && cmd_start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            runs_q       <= '0;
            rst_cnt      <= '0;
            cnt          <= '0;
            kernel_reset <= 1'b0;
            kernel_start <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            run_idx      <= '0;
            run_cycles   <= '0;
            batch_done   <= 1'b0;
            timed_out    <= 1'b0;
            aborted      <= 1'b0;
            total_cycles <= '0;
        end else begin
            res_valid    <= 1'b0;
            batch_done   <= 1'b0;
            kernel_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    kernel_reset <= 1'b1;
                    busy         <= 1'b0;
                    if (cmd_start) begin
                        total_cycles <= '0;
                        timed_out    <= 1'b0;
                        aborted      <= 1'b0;
                        if (cmd_runs != '0) begin
                            runs_q       <= cmd_runs;
                            run_idx      <= '0;
                            rst_cnt      <= '0;
                            kernel_reset <= 1'b0;
                            busy         <= 1'b1;
                            state        <= StKrst;
                        end else begin
                            batch_done <= 1'b1;
                        end
                    end
                end
                StKrst: begin
                    if (cmd_abort) begin
                        aborted      <= 1'b1;
                        batch_done   <= 1'b1;
                        kernel_reset <= 1'b1;
                        state        <= StFinish;
                    end else if (rst_cnt == RstLast) begin
                        kernel_reset <= 1'b1;
                        kernel_start <= 1'b1;
                        state        <= StStart;
                    end else begin
                        rst_cnt <= rst_cnt + RstW'(1);
                    end
                end
                StStart: begin
                    cnt <= CNT_W'(1);
                    if (cmd_abort) begin
                        aborted    <= 1'b1;
                        batch_done <= 1'b1;
                        state      <= StFinish;
                    end else if (kernel_done) begin
                        run_cycles <= CNT_W'(1);
                        res_valid  <= 1'b1;
                        state      <= StReport;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    cnt <= cur_cycle;
                    if (cmd_abort) begin
                        aborted    <= 1'b1;
                        batch_done <= 1'b1;
                        state      <= StFinish;
                    end else if (kernel_done) begin
                        run_cycles <= cur_cycle;
                        res_valid  <= 1'b1;
                        state      <= StReport;
                    end else if (cur_cycle == TimeoutVal) begin
                        timed_out  <= 1'b1;
                        run_cycles <= cur_cycle;
                        res_valid  <= 1'b1;
                        state      <= StReport;
                    end
                end
                StReport: begin
                    total_cycles <= total_sum[CNT_W] ? CntMax : total_sum[CNT_W-1:0];
                    if (timed_out || last_run) begin
                        batch_done <= 1'b1;
                        state      <= StFinish;
                    end else begin
                        run_idx      <= run_idx + RUNS_W'(1);
                        rst_cnt      <= '0;
                        kernel_reset <= 1'b0;
                        state        <= StKrst;
                    end
                end
                StFinish: begin
                    busy         <= 1'b0;
                    kernel_reset <= 1'b1;
                    state        <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef HLS_RUN_MINMAX_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (accept) begin
            min_cycles <= '1;
            max_cycles <= '0;
        end else if (state == StReport) begin
            if (run_cycles < min_cycles) min_cycles <= run_cycles;
            if (run_cycles > max_cycles) max_cycles <= run_cycles;
        end
    end
`else
    assign min_cycles = '0;
    assign max_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_run_controller.sv
// Scoreboard bench for hls_run_controller: stimulus pushes expected results, a monitor pops them.
module tb_hls_run_controller;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned RUNS_W = 8;
`ifdef HLS_RUN_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_start = 1'b0;
    logic [RUNS_W-1:0] cmd_runs = '0;
    logic              cmd_abort = 1'b0;
    logic              kernel_done = 1'b0;
    logic              kernel_reset, kernel_start, busy, res_valid, batch_done, timed_out, aborted;
    logic [RUNS_W-1:0] run_idx;
    logic [CNT_W-1:0]  run_cycles, total_cycles, min_cycles, max_cycles;

    hls_run_controller #(
        .CNT_W(CNT_W), .RUNS_W(RUNS_W), .TIMEOUT(50), .RST_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_runs(cmd_runs),
        .cmd_abort(cmd_abort), .kernel_reset(kernel_reset), .kernel_start(kernel_start),
        .kernel_done(kernel_done), .busy(busy), .res_valid(res_valid), .run_idx(run_idx),
        .run_cycles(run_cycles), .batch_done(batch_done), .timed_out(timed_out),
        .aborted(aborted), .total_cycles(total_cycles), .min_cycles(min_cycles),
        .max_cycles(max_cycles)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {logic [RUNS_W-1:0] idx; logic [CNT_W-1:0] cyc;} res_t;
    typedef struct {logic [CNT_W-1:0] total, mn, mx; logic to, ab;} bat_t;
    res_t res_q[$];
    bat_t bat_q[$];

    task automatic exp_res(input int idx, input int cyc);
        res_t r;
        r.idx = RUNS_W'(idx);
        r.cyc = CNT_W'(cyc);
        res_q.push_back(r);
    endtask

    task automatic exp_bat(input logic [CNT_W-1:0] total, input logic [CNT_W-1:0] mn,
                           input logic [CNT_W-1:0] mx, input logic to, input logic ab);
        bat_t b;
        b.total = total;
        b.mn    = MM ? mn : '0;
        b.mx    = MM ? mx : '0;
        b.to    = to;
        b.ab    = ab;
        bat_q.push_back(b);
    endtask

    // Kernel model: done is high in the lat-th cycle counting the start cycle as 1 (lat=0: never)
    int  lat_tab[4];
    int  kstarts = 0;
    int  kbase = 0;
    int  kc = 0;
    int  cur_lat = 0;
    bit  kact = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            kact        = 1'b0;
            kernel_done = 1'b0;
        end else begin
            if (kernel_start) begin
                cur_lat = lat_tab[(kstarts - kbase) % 4];
                kstarts++;
                kc   = 1;
                kact = 1'b1;
            end else if (kact) begin
                kc++;
            end
            kernel_done = kact && (cur_lat != 0) && (kc == cur_lat);
            if (kernel_done) kact = 1'b0;
        end
    end

    // Monitor
    always @(negedge clock) begin
        res_t r;
        bat_t b;
        if (reset) begin
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_res: got idx=%0d cycles=%0d expected none",
                             run_idx, run_cycles);
                end else begin
                    r = res_q.pop_front();
                    chk("run_idx", run_idx, r.idx);
                    chk("run_cycles", run_cycles, r.cyc);
                end
            end
            if (batch_done) begin
                if (bat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_batch_done: got 1 expected 0");
                end else begin
                    b = bat_q.pop_front();
                    chk("total_cycles", total_cycles, b.total);
                    chk("min_cycles", min_cycles, b.mn);
                    chk("max_cycles", max_cycles, b.mx);
                    chk("timed_out", timed_out, b.to);
                    chk("aborted", aborted, b.ab);
                end
            end
        end
    end

    task automatic pulse_start(input int runs);
        @(negedge clock);
        cmd_runs  = RUNS_W'(runs);
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
    endtask

    task automatic wait_batch(input string name);
        int n = 0;
        while (!batch_done && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk(name, batch_done, 1);
        @(negedge clock);
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while ((kstarts - kbase) < target && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("start_seen", ((kstarts - kbase) >= target), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_kernel_reset", kernel_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_kernel_start", kernel_start, 0);
        chk("rst_total", total_cycles, 0);
        chk("rst_min", min_cycles, MM ? 64'hFFFF_FFFF : 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_kernel_reset", kernel_reset, 1);

        // 1: three runs of 10 cycles
        lat_tab = '{10, 10, 10, 10};
        kbase = kstarts;
        exp_res(0, 10); exp_res(1, 10); exp_res(2, 10);
        exp_bat(30, 10, 10, 0, 0);
        pulse_start(3);
        chk("busy_after_start", busy, 1);
        wait_batch("t1_batch_done");
        chk("t1_starts", kstarts - kbase, 3);
        chk("t1_busy_clear", busy, 0);

        // 2: kernel never finishes; timeout ends the batch after one run
        lat_tab = '{0, 0, 0, 0};
        kbase = kstarts;
        exp_res(0, 50);
        exp_bat(50, 50, 50, 1, 0);
        pulse_start(4);
        wait_batch("t2_batch_done");
        chk("t2_starts", kstarts - kbase, 1);

        // 3: zero runs completes on the following cycle without touching the kernel
        kbase = kstarts;
        exp_bat(0, 32'hFFFF_FFFF, 0, 0, 0);
        pulse_start(0);
        chk("t3_done_next_cycle", batch_done, 1);
        @(negedge clock);
        chk("t3_done_one_cycle", batch_done, 0);
        chk("t3_no_start", kstarts - kbase, 0);

        // 4: mixed latencies
        lat_tab = '{5, 20, 7, 0};
        kbase = kstarts;
        exp_res(0, 5); exp_res(1, 20); exp_res(2, 7);
        exp_bat(32, 5, 20, 0, 0);
        pulse_start(3);
        wait_batch("t4_batch_done");

        // 5: abort during the second run; a start while busy is ignored
        lat_tab = '{10, 10, 10, 10};
        kbase = kstarts;
        exp_res(0, 10);
        exp_bat(10, 10, 10, 0, 1);
        pulse_start(3);
        pulse_start(0);
        chk("t5_busy_start_ignored", batch_done, 0);
        wait_starts(2);
        repeat (3) @(negedge clock);
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_abort = 1'b0;
        wait_batch("t5_batch_done");
        chk("t5_starts", kstarts - kbase, 2);
        chk("t5_aborted_sticky", aborted, 1);

        // 6: async reset mid-WAIT, then a normal batch
        lat_tab = '{0, 0, 0, 0};
        kbase = kstarts;
        pulse_start(2);
        wait_starts(1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_kernel_reset", kernel_reset, 0);
        chk("t6_total", total_cycles, 0);
        chk("t6_aborted", aborted, 0);
        chk("t6_min", min_cycles, MM ? 64'hFFFF_FFFF : 64'd0);
        @(negedge clock);
        reset = 1'b1;
        lat_tab = '{3, 3, 3, 3};
        kbase = kstarts;
        exp_res(0, 3);
        exp_bat(3, 3, 3, 0, 0);
        pulse_start(1);
        wait_batch("t6_batch_done");

        repeat (3) @(negedge clock);
        chk("queues_empty", res_q.size() + bat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
